// File: rtl/cmd_arbiter_pclk.sv
// rtl/cmd_arbiter_pclk.sv - round-robin arbiter and command sequencer for the PCLK handshake master
// Grants one requester at a time, issues its command, waits for completion or aborts on timeout.
module cmd_arbiter_pclk #(
   parameter int NREQ    = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 10,
   parameter int TIMEOUT = 255
) (
   input  logic                     PCLK,
   input  logic                     RESET_pclk,
   input  logic [NREQ-1:0]          req_vld,
   input  logic [3*NREQ-1:0]        req_cmd,
   input  logic [ADDR_W*NREQ-1:0]   req_addr,
   input  logic [DATA_W*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          req_done,
   output logic [DATA_W-1:0]        req_rdata,
   output logic                     req_err,
   output logic                     busy,
   output logic [2:0]               CMD,
   output logic [ADDR_W-1:0]        ADDR,
   output logic [DATA_W-1:0]        WDATA,
   output logic                     ABORT,
   input  logic                     READY_pclk,
   input  logic [DATA_W-1:0]        RDATA_pclk
);

   localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);
   localparam logic [2:0] OP_READ = 3'd1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    idx_q, idx_d;
   logic [2:0]          op_q, op_d;
   logic [2:0]          cmd_q, cmd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                abort_q, abort_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [NREQ-1:0]     done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [1:0]          acnt_q, acnt_d;

   logic                found;
   logic [PTR_W-1:0]    win;
   int                  j;
   logic [2:0]          win_cmd;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;

   // Search starts one past the last winner so every requester is reached within NREQ grants.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!found && req_vld[j[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = j[PTR_W-1:0];
         end
      end
      win_cmd   = req_cmd[3*int'(win) +: 3];
      win_addr  = req_addr[ADDR_W*int'(win) +: ADDR_W];
      win_wdata = req_wdata[DATA_W*int'(win) +: DATA_W];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      op_d    = op_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      abort_d = abort_q;
      grant_d = grant_q;
      done_d  = '0;
      rdata_d = rdata_q;
      err_d   = err_q;
      tcnt_d  = tcnt_q;
      acnt_d  = acnt_q;
      case (state_q)
         S_IDLE: begin
            if (found && READY_pclk) begin
               ptr_d        = win;
               idx_d        = win;
               op_d         = win_cmd;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               if (win_cmd >= 3'd1 && win_cmd <= 3'd5) begin
                  state_d = S_ISSUE;
                  cmd_d   = win_cmd;
                  addr_d  = win_addr;
                  wdata_d = win_wdata;
                  tcnt_d  = '0;
               end else begin
                  state_d     = S_DONE;
                  done_d[win] = 1'b1;
                  err_d       = 1'b1;
                  rdata_d     = '0;
               end
            end
         end
         S_ISSUE: begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (!READY_pclk) begin
               cmd_d   = 3'd0;
               state_d = S_WAIT;
            end else if (tcnt_q >= TLAST) begin
               cmd_d   = 3'd0;
               abort_d = 1'b1;
               acnt_d  = '0;
               state_d = S_ABORT;
            end
         end
         S_WAIT: begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (READY_pclk) begin
               rdata_d       = (op_q == OP_READ) ? RDATA_pclk : '0;
               err_d         = 1'b0;
               done_d[idx_q] = 1'b1;
               state_d       = S_DONE;
            end else if (tcnt_q >= TLAST) begin
               abort_d = 1'b1;
               acnt_d  = '0;
               state_d = S_ABORT;
            end
         end
         S_ABORT: begin
            acnt_d = acnt_q + 2'd1;
            if (acnt_q == 2'd3) begin
               abort_d       = 1'b0;
               done_d[idx_q] = 1'b1;
               err_d         = 1'b1;
               rdata_d       = '0;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            grant_d = '0;
            err_d   = 1'b0;
            rdata_d = '0;
            abort_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge PCLK or posedge RESET_pclk) begin
      if (RESET_pclk) begin
         state_q <= S_IDLE;
         ptr_q   <= PTR_W'(NREQ - 1);
         idx_q   <= '0;
         op_q    <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         abort_q <= 1'b0;
         grant_q <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         tcnt_q  <= '0;
         acnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         abort_q <= abort_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         tcnt_q  <= tcnt_d;
         acnt_q  <= acnt_d;
      end
   end

   assign grant     = grant_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign req_err   = err_q;
   assign busy      = busy_q;
   assign CMD       = cmd_q;
   assign ADDR      = addr_q;
   assign WDATA     = wdata_q;
   assign ABORT     = abort_q;

endmodule

// File: tb/tb_cmd_arbiter_pclk.sv
// tb/tb_cmd_arbiter_pclk.sv - self-checking bench for cmd_arbiter_pclk
// Transaction-level model: round-robin winner from a pointer, timing from relative cycle counts.
module tb_cmd_arbiter_pclk;
   localparam int NREQ = 4;
   localparam int AW   = 10;
   localparam int DW   = 10;
   localparam int TO   = 16;

   logic              PCLK = 1'b0;
   logic              RESET_pclk;
   logic [NREQ-1:0]   req_vld;
   logic [3*NREQ-1:0] req_cmd;
   logic [AW*NREQ-1:0] req_addr;
   logic [DW*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   grant, req_done;
   logic [DW-1:0]     req_rdata;
   logic              req_err, busy;
   logic [2:0]        CMD;
   logic [AW-1:0]     ADDR;
   logic [DW-1:0]     WDATA;
   logic              ABORT;
   logic              READY_pclk;
   logic [DW-1:0]     RDATA_pclk;

   int total = 0;
   int bad   = 0;
   int ptr_m;

   cmd_arbiter_pclk #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .RESET_pclk(RESET_pclk),
      .req_vld(req_vld), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
      .grant(grant), .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err), .busy(busy),
      .CMD(CMD), .ADDR(ADDR), .WDATA(WDATA), .ABORT(ABORT),
      .READY_pclk(READY_pclk), .RDATA_pclk(RDATA_pclk)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2ms;
      $fatal(1, "FAIL watchdog: simulation did not finish in time");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] m, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         int q;
         q = (p + k) % NREQ;
         if (m[q]) return q;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_cmd[3*i +: 3]     = c;
      req_addr[AW*i +: AW]  = a;
      req_wdata[DW*i +: DW] = d;
   endtask

   // Starts at a negedge with the DUT idle and requests already presented; returns at a negedge, idle.
   task automatic run_txn(input int d1, input int d2, input logic [DW-1:0] rd, input bit hold,
                          output int w, output logic [NREQ-1:0] g_obs);
      logic [2:0]    c;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      bit            valid, aborted;
      int            iss, wx, ab, xe, cmd_until;
      w = pick(req_vld, ptr_m);
      if (w < 0) $fatal(1, "FAIL run_txn started with no requester");
      c  = req_cmd[3*w +: 3];
      a  = req_addr[AW*w +: AW];
      wd = req_wdata[DW*w +: DW];
      valid = (c >= 3'd1 && c <= 3'd5);
      READY_pclk = 1'b1;
      RDATA_pclk = DW'($urandom);
      @(posedge PCLK); @(negedge PCLK);
      ptr_m = w;
      g_obs = grant;
      chk("grant", grant, 64'(1) << w);
      chk("busy_on", busy, 1);
      chk("abort_start", ABORT, 0);
      if (!valid) begin
         chk("inv_cmd", CMD, 0);
         chk("inv_done", req_done, 64'(1) << w);
         chk("inv_err", req_err, 1);
         chk("inv_rdata", req_rdata, 0);
      end else begin
         chk("cmd_issue", CMD, c);
         chk("addr_issue", ADDR, a);
         chk("wdata_issue", WDATA, wd);
         chk("done_early", req_done, 0);
         iss = d1 + 1;
         wx  = d1 + d2 + 1;
         if (iss > TO) begin
            aborted = 1'b1;
            ab = TO;
         end else begin
            ab = (iss + 1 > TO) ? iss + 1 : TO;
            aborted = (wx > ab);
         end
         xe = aborted ? ab + 4 : wx;
         cmd_until = (iss < TO) ? iss : TO;
         for (int k = 1; k <= xe; k++) begin
            READY_pclk = (k <= d1) ? 1'b1 : (k <= d1 + d2) ? 1'b0 : 1'b1;
            RDATA_pclk = (k == wx) ? rd : DW'($urandom);
            @(posedge PCLK); @(negedge PCLK);
            chk("cmd_cycle", CMD, (k < cmd_until) ? c : 3'd0);
            chk("abort_cycle", ABORT, (aborted && k >= ab && k < ab + 4) ? 1 : 0);
            chk("grant_held", grant, 64'(1) << w);
            if (k < xe) chk("done_cycle", req_done, 0);
         end
         chk("done_pulse", req_done, 64'(1) << w);
         chk("done_err", req_err, aborted ? 1 : 0);
         chk("done_rdata", req_rdata, (aborted || c != 3'd1) ? 0 : rd);
         chk("addr_hold", ADDR, a);
      end
      if (hold) set_req(w, 3'd1, AW'($urandom), DW'($urandom));
      else req_vld[w] = 1'b0;
      READY_pclk = 1'b0;
      @(posedge PCLK); @(negedge PCLK);
      chk("idle_busy", busy, 0);
      chk("idle_grant", grant, 0);
      chk("idle_done", req_done, 0);
      chk("idle_abort", ABORT, 0);
      chk("idle_cmd", CMD, 0);
   endtask

   initial begin
      int w;
      logic [NREQ-1:0] g;
      int fair_seq [6] = '{0, 1, 2, 3, 0, 1};
      int d1, d2;
      RESET_pclk = 1'b1;
      req_vld = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
      READY_pclk = 1'b0; RDATA_pclk = '0;
      repeat (2) @(negedge PCLK);
      chk("rst_cmd", CMD, 0);
      chk("rst_addr", ADDR, 0);
      chk("rst_wdata", WDATA, 0);
      chk("rst_abort", ABORT, 0);
      chk("rst_grant", grant, 0);
      chk("rst_done", req_done, 0);
      chk("rst_rdata", req_rdata, 0);
      chk("rst_err", req_err, 0);
      chk("rst_busy", busy, 0);
      RESET_pclk = 1'b0;
      ptr_m = NREQ - 1;
      @(negedge PCLK);

      // fairness with every slot requesting READ continuously
      for (int i = 0; i < NREQ; i++) set_req(i, 3'd1, AW'($urandom), DW'($urandom));
      req_vld = '1;
      for (int i = 0; i < 6; i++) begin
         run_txn(1, 2, DW'($urandom), 1'b1, w, g);
         chk("fair_order", g, 64'(1) << fair_seq[i]);
      end
      req_vld = '0;

      // basic write
      set_req(0, 3'd2, 10'h02A, 10'h155);
      req_vld = 4'b0001;
      run_txn(2, 6, '0, 1'b0, w, g);

      // read data return
      set_req(1, 3'd1, AW'($urandom), DW'($urandom));
      req_vld = 4'b0010;
      run_txn(1, 3, 10'h3C5, 1'b0, w, g);

      // READY never drops: abort from ISSUE
      set_req(0, 3'd2, AW'($urandom), DW'($urandom));
      req_vld = 4'b0001;
      run_txn(100, 1, '0, 1'b0, w, g);

      // invalid command, then req3 should win next
      set_req(2, 3'd6, AW'($urandom), DW'($urandom));
      req_vld = 4'b0100;
      run_txn(1, 1, '0, 1'b0, w, g);
      for (int i = 0; i < NREQ; i++) set_req(i, 3'd1, AW'($urandom), DW'($urandom));
      req_vld = 4'b1111;
      run_txn(0, 2, DW'($urandom), 1'b0, w, g);
      chk("after_invalid", g, 4'b1000);
      req_vld = '0;

      // timeout boundaries: exit on the last cycle wins, one cycle later aborts
      set_req(0, 3'd2, AW'($urandom), DW'($urandom));
      req_vld = 4'b0001;
      run_txn(15, 1, '0, 1'b0, w, g);
      set_req(0, 3'd1, AW'($urandom), DW'($urandom));
      req_vld = 4'b0001;
      run_txn(3, 12, DW'($urandom), 1'b0, w, g);
      set_req(0, 3'd1, AW'($urandom), DW'($urandom));
      req_vld = 4'b0001;
      run_txn(3, 13, DW'($urandom), 1'b0, w, g);

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, 3'($urandom_range(0, 7)), AW'($urandom), DW'($urandom));
         req_vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         d1 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
         d2 = ($urandom_range(0, 4) == 0) ? 20 : $urandom_range(1, 9);
         run_txn(d1, d2, DW'($urandom), bit'($urandom_range(0, 1)), w, g);
         req_vld = '0;
      end

      // reset during WAIT
      set_req(0, 3'd2, AW'($urandom), DW'($urandom));
      req_vld = 4'b0001;
      READY_pclk = 1'b1;
      @(posedge PCLK); @(negedge PCLK);
      chk("mid_busy", busy, 1);
      READY_pclk = 1'b0;
      @(posedge PCLK); @(negedge PCLK);
      chk("mid_wait_cmd", CMD, 0);
      #2 RESET_pclk = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_done", req_done, 0);
      chk("mid_rst_addr", ADDR, 0);
      chk("mid_rst_wdata", WDATA, 0);
      chk("mid_rst_err", req_err, 0);
      @(negedge PCLK);
      set_req(3, 3'd1, AW'($urandom), DW'($urandom));
      req_vld = 4'b1001;
      READY_pclk = 1'b1;
      repeat (2) begin
         @(negedge PCLK);
         chk("mid_rst_hold_done", req_done, 0);
         chk("mid_rst_hold_grant", grant, 0);
      end
      RESET_pclk = 1'b0;
      ptr_m = NREQ - 1;
      run_txn(1, 2, DW'($urandom), 1'b0, w, g);
      chk("rst_first_winner", g, 4'b0001);
      req_vld = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
